// File: rtl/multdiv_pkg.sv
// multdiv_pkg
//   Shared definitions for the multiply/divide front-end controller:
//   datapath width, default timeout and counter width, and the FSM state
//   encoding used by multdiv_ctrl and exposed on its debug port.
package multdiv_pkg;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_DIV_WAIT = 2'b10,
    ST_DONE     = 2'b11
  } state_e;

endpackage

// File: rtl/multdiv_op_timer.sv
// op_timer
//   Wait-cycle counter guarding against an iterative unit that never answers.
//   Ports:
//     clock      rising-edge clock
//     reset_n    synchronous active-low reset (count -> 0)
//     clr_i      synchronous clear, wins over enable
//     en_i       count one cycle
//     expired_o  count has reached TIMEOUT (unsigned equality on CNT_W bits)
module op_timer
  import multdiv_pkg::*;
#(
  parameter int CNT_W_P   = CNT_W,
  parameter int TIMEOUT_P = TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W_P-1:0] LIMIT = CNT_W_P'(TIMEOUT_P);
  localparam logic [CNT_W_P-1:0] ONE   = CNT_W_P'(1);

  logic [CNT_W_P-1:0] cnt_q;
  logic [CNT_W_P-1:0] cnt_d;
  logic [CNT_W_P-1:0] cnt_inc;

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
//   Front-end controller between the execute stage and the iterative
//   multiplier / divider. Latches operands on a request, pulses the matching
//   unit start for one cycle, waits for the unit's first ready (or a timeout)
//   and presents the captured result with a one-cycle data_resultRDY pulse.
//   Ports:
//     clock, reset_n                  clock, synchronous active-low reset
//     ctrl_MULT, ctrl_DIV             single-cycle requests (both = illegal)
//     data_operandA/B                 operands sampled on accept
//     unit_A/B                        latched operands held for the unit
//     mult_start, div_start           one-cycle start pulses to the units
//     mult_P/rdy/exc, div_Q/rdy/exc   unit results
//     data_result, data_exception     registered result / exception
//     data_resultRDY                  one-cycle result-valid pulse
//     busy                            state != IDLE (pipeline stall)
//     dbg_state_o                     current FSM state
//   Handshake: a request is accepted in any state on the edge where it is
//   sampled high; the unit's rdy is honoured only in the matching WAIT state
//   and only when its start pulse is not currently high; data_resultRDY is
//   high for exactly the one cycle spent in DONE and needs no acknowledge.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH_P   = WIDTH,
  parameter int TIMEOUT_P = TIMEOUT,
  parameter int CNT_W_P   = CNT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [WIDTH_P-1:0] data_operandA,
  input  logic [WIDTH_P-1:0] data_operandB,
  output logic [WIDTH_P-1:0] unit_A,
  output logic [WIDTH_P-1:0] unit_B,
  output logic               mult_start,
  output logic               div_start,
  input  logic [WIDTH_P-1:0] mult_P,
  input  logic               mult_rdy,
  input  logic               mult_exc,
  input  logic [WIDTH_P-1:0] div_Q,
  input  logic               div_rdy,
  input  logic               div_exc,
  output logic [WIDTH_P-1:0] data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy,
  output state_e             dbg_state_o
);

  state_e             state_q, state_d;
  logic [WIDTH_P-1:0] a_q, a_d;
  logic [WIDTH_P-1:0] b_q, b_d;
  logic [WIDTH_P-1:0] res_q, res_d;
  logic               exc_q, exc_d;
  logic               mstart_q, mstart_d;
  logic               dstart_q, dstart_d;

  logic req_mul, req_div, req_bad;
  logic tmr_clr, tmr_en, tmr_expired;

  assign req_mul = ctrl_MULT & ~ctrl_DIV;
  assign req_div = ctrl_DIV  & ~ctrl_MULT;
  assign req_bad = ctrl_MULT &  ctrl_DIV;

  // Only WAIT cycles count toward the timeout; leaving WAIT freezes it
  // until the next accept clears it.
  assign tmr_en = (state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT);

  op_timer #(
    .CNT_W_P   (CNT_W_P),
    .TIMEOUT_P (TIMEOUT_P)
  ) u_op_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // State and capture registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      mstart_q <= 1'b0;
      dstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      mstart_q <= mstart_d;
      dstart_q <= dstart_d;
    end
  end

  // Next state. A new request wins in every state: in WAIT it drops the
  // running operation silently, in DONE the ready pulse still goes out
  // because DONE itself is what drives data_resultRDY this cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    exc_d    = exc_q;
    mstart_d = 1'b0;
    dstart_d = 1'b0;
    tmr_clr  = 1'b0;
    if (req_mul) begin
      a_d      = data_operandA;
      b_d      = data_operandB;
      mstart_d = 1'b1;
      tmr_clr  = 1'b1;
      state_d  = ST_MUL_WAIT;
    end else if (req_div) begin
      a_d      = data_operandA;
      b_d      = data_operandB;
      dstart_d = 1'b1;
      tmr_clr  = 1'b1;
      state_d  = ST_DIV_WAIT;
    end else if (req_bad) begin
      res_d   = '0;
      exc_d   = 1'b1;
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_MUL_WAIT: begin
          // A rdy seen while start is high is the unit's idle ready, not ours.
          if (mult_rdy && !mstart_q) begin
            res_d   = mult_P;
            exc_d   = mult_exc;
            state_d = ST_DONE;
          end else if (tmr_expired) begin
            res_d   = '0;
            exc_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DIV_WAIT: begin
          if (div_rdy && !dstart_q) begin
            res_d   = div_Q;
            exc_d   = div_exc;
            state_d = ST_DONE;
          end else if (tmr_expired) begin
            res_d   = '0;
            exc_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    unit_A         = a_q;
    unit_B         = b_q;
    mult_start     = mstart_q;
    div_start      = dstart_q;
    data_result    = res_q;
    data_exception = exc_q;
    data_resultRDY = (state_q == ST_DONE);
    busy           = (state_q != ST_IDLE);
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: the multiplier/divider are played by
// driver tasks returning hand-computed results.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] unit_A, unit_B;
  logic        mult_start, div_start;
  logic [31:0] mult_P, div_Q;
  logic        mult_rdy, mult_exc, div_rdy, div_exc;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_pulses = 0;

  multdiv_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .unit_A         (unit_A),
    .unit_B         (unit_B),
    .mult_start     (mult_start),
    .div_start      (div_start),
    .mult_P         (mult_P),
    .mult_rdy       (mult_rdy),
    .mult_exc       (mult_exc),
    .div_Q          (div_Q),
    .div_rdy        (div_rdy),
    .div_exc        (div_exc),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count ready pulses on the inactive edge.
  always @(negedge clock) begin
    if (data_resultRDY) rdy_pulses++;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input bit is_mul, input bit is_div, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = is_div;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // One unit answer: rdy high for one cycle, sampled on the next edge.
  task automatic unit_answer(input bit is_div, input logic [31:0] res, input bit exc);
    if (is_div) begin
      div_Q = res; div_exc = exc; div_rdy = 1'b1;
    end else begin
      mult_P = res; mult_exc = exc; mult_rdy = 1'b1;
    end
    tick();
    mult_rdy = 1'b0;
    div_rdy  = 1'b0;
  endtask

  // Full operation with a unit latency of lat cycles after the start cycle.
  task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] res, input bit exc);
    int p0;
    p0 = rdy_pulses;
    request(!is_div, is_div, a, b);
    check_eq({tag, "_mstart"}, {31'b0, mult_start}, {31'b0, !is_div});
    check_eq({tag, "_dstart"}, {31'b0, div_start}, {31'b0, is_div});
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
    repeat (lat) tick();
    check_eq({tag, "_startlow"}, {30'b0, mult_start, div_start}, 32'd0);
    check_eq({tag, "_unitA"}, unit_A, a);
    check_eq({tag, "_unitB"}, unit_B, b);
    check_eq({tag, "_notrdy"}, {31'b0, data_resultRDY}, 32'd0);
    unit_answer(is_div, res, exc);
    check_eq({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd1);
    check_eq({tag, "_res"}, data_result, res);
    check_eq({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exc});
    tick();
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_onepulse"}, rdy_pulses - p0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int seen;
    reset_n = 1'b0;
    ctrl_MULT = 0; ctrl_DIV = 0;
    data_operandA = 32'h1234_5678; data_operandB = 32'h9abc_def0;
    mult_P = 0; mult_rdy = 0; mult_exc = 0;
    div_Q = 0; div_rdy = 0; div_exc = 0;
    tick(); tick();
    check_eq("rst_unitA", unit_A, 32'd0);
    check_eq("rst_unitB", unit_B, 32'd0);
    check_eq("rst_result", data_result, 32'd0);
    check_eq("rst_flags", {26'b0, data_exception, data_resultRDY, mult_start, div_start, busy, 1'b0}, 32'd0);
    check_eq("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    reset_n = 1'b1;
    tick();

    // 7 * -3 = -21
    run_op("mul", 1'b0, 32'd7, 32'hFFFF_FFFD, 3, 32'hFFFF_FFEB, 1'b0);

    // Overflow multiply; unit's idle ready is high during the start cycle.
    request(1'b1, 1'b0, 32'h4000_0000, 32'd4);
    mult_P = 32'hDEAD_BEEF; mult_exc = 1'b0; mult_rdy = 1'b1;
    tick();
    mult_rdy = 1'b0;
    check_eq("ovf_startrdy_ignored", {31'b0, data_resultRDY}, 32'd0);
    check_eq("ovf_still_wait", {30'b0, dbg_state}, {30'b0, ST_MUL_WAIT});
    tick();
    unit_answer(1'b0, 32'd0, 1'b1);
    check_eq("ovf_rdy", {31'b0, data_resultRDY}, 32'd1);
    check_eq("ovf_exc", {31'b0, data_exception}, 32'd1);
    tick();

    // 100 / 7 = 14, then divide by zero.
    run_op("div", 1'b1, 32'd100, 32'd7, 4, 32'd14, 1'b0);
    check_eq("div_hold_res", data_result, 32'd14);
    run_op("div0", 1'b1, 32'd100, 32'd0, 2, 32'hFFFF_FFFF, 1'b1);

    // Abort/restart: mult then div five cycles later, stale mult_rdy.
    p0 = rdy_pulses;
    request(1'b1, 1'b0, 32'd5, 32'd5);
    repeat (4) tick();
    request(1'b0, 1'b1, 32'd9, 32'd3);
    check_eq("abt_dstart", {30'b0, mult_start, div_start}, 32'd1);
    check_eq("abt_unitA", unit_A, 32'd9);
    check_eq("abt_state", {30'b0, dbg_state}, {30'b0, ST_DIV_WAIT});
    tick();
    unit_answer(1'b0, 32'd25, 1'b0);
    check_eq("abt_stale_ignored", {31'b0, data_resultRDY}, 32'd0);
    tick();
    unit_answer(1'b1, 32'd3, 1'b0);
    check_eq("abt_rdy", {31'b0, data_resultRDY}, 32'd1);
    check_eq("abt_res", data_result, 32'd3);
    tick();
    check_eq("abt_onepulse", rdy_pulses - p0, 32'd1);

    // Timeout: no unit ever answers.
    request(1'b0, 1'b1, 32'd50, 32'd5);
    seen = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (data_resultRDY) begin
        seen = i;
        break;
      end
    end
    check_eq("tmo_latency", seen, 32'd65);
    check_eq("tmo_res", data_result, 32'd0);
    check_eq("tmo_exc", {31'b0, data_exception}, 32'd1);
    tick();
    check_eq("tmo_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});

    // Reset in MUL_WAIT, then a late mult_rdy.
    request(1'b1, 1'b0, 32'd11, 32'd13);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("mrst_unitA", unit_A, 32'd0);
    check_eq("mrst_result", data_result, 32'd0);
    check_eq("mrst_flags", {27'b0, data_exception, data_resultRDY, mult_start, div_start, busy}, 32'd0);
    p0 = rdy_pulses;
    tick();
    unit_answer(1'b0, 32'd143, 1'b0);
    tick(); tick();
    check_eq("mrst_no_rdy", rdy_pulses - p0, 32'd0);
    check_eq("mrst_idle", {31'b0, busy}, 32'd0);

    // Illegal request, with a new multiply issued in its DONE cycle.
    run_op("pre", 1'b1, 32'd20, 32'd4, 1, 32'd5, 1'b0);
    p0 = rdy_pulses;
    request(1'b1, 1'b1, 32'd1, 32'd2);
    check_eq("ill_nostart", {30'b0, mult_start, div_start}, 32'd0);
    check_eq("ill_rdy", {31'b0, data_resultRDY}, 32'd1);
    check_eq("ill_res", data_result, 32'd0);
    check_eq("ill_exc", {31'b0, data_exception}, 32'd1);
    request(1'b1, 1'b0, 32'd3, 32'd4);
    check_eq("b2b_mstart", {31'b0, mult_start}, 32'd1);
    check_eq("b2b_unitA", unit_A, 32'd3);
    tick();
    unit_answer(1'b0, 32'd12, 1'b0);
    check_eq("b2b_rdy", {31'b0, data_resultRDY}, 32'd1);
    check_eq("b2b_res", data_result, 32'd12);
    check_eq("b2b_exc", {31'b0, data_exception}, 32'd0);
    tick();
    check_eq("b2b_twopulses", rdy_pulses - p0, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
